// File: rtl/usb1bd_pe_pkg.sv
// ----------------------------------------------------------------------------
// usb1bd_pe_pkg
// Shared types and constants for the USB 1.1 device protocol-engine sequencer:
// FSM state encoding, handshake PID codes, the registered-output bundle, the
// default turnaround timeout, and a helper to size the timeout counter.
// No ports (package).
// ----------------------------------------------------------------------------
package usb1bd_pe_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RX_DATA,
        ST_RX_HS,
        ST_TX_DATA,
        ST_WAIT_ACK
    } pe_state_t;

    // Handshake selector understood by the packet assembler.
    typedef enum logic [1:0] {
        HS_ACK   = 2'b00,
        HS_NAK   = 2'b01,
        HS_STALL = 2'b10
    } hs_pid_t;

    // Every sequencer output is a flop; bundling them lets reset be one line.
    typedef struct packed {
        logic        tx_hs_req;
        hs_pid_t     tx_hs_pid;
        logic        tx_data_req;
        logic        tx_data_pid;
        logic [3:0]  ep_sel;
        logic        rx_en;
        logic        out_commit;
        logic        out_drop;
        logic        in_commit;
        logic        setup_rcvd;
        logic        sof_pulse;
        logic [10:0] sof_frame;
    } pe_out_t;

    localparam int TO_CYC_DEF = 96;

    // Bits needed to count 0 .. cyc-1 (at least one bit).
    function automatic int timer_width(input int cyc);
        return (cyc > 1) ? $clog2(cyc) : 1;
    endfunction

endpackage

// File: rtl/usb1bd_pe_ctrl_if.sv
// ----------------------------------------------------------------------------
// usb1bd_pe_ctrl_if
// Packet-level bus between the protocol engine and the packet
// disassembler/assembler pair.
//   slave  : the protocol engine (consumes decoded PIDs/tokens, drives tx reqs)
//   master : the packet disassembler/assembler side
// Signals:
//   token_valid, token_fadr[6:0], token_endp[3:0], crc5_err  token strobe/fields
//   pid_OUT/IN/SETUP/SOF/ACK/DATA0/DATA1                     decoded PID levels
//   frame_no[10:0]                                           SOF frame number
//   rx_data_done, crc16_err, seq_err                         end of data packet
//   tx_done                                                  assembler finished
//   tx_hs_req, tx_hs_pid[1:0]                                handshake request
//   tx_data_req, tx_data_pid                                 data packet request
// ----------------------------------------------------------------------------
interface usb1bd_pe_ctrl_if;

    logic        token_valid;
    logic [6:0]  token_fadr;
    logic [3:0]  token_endp;
    logic        crc5_err;
    logic        pid_OUT;
    logic        pid_IN;
    logic        pid_SETUP;
    logic        pid_SOF;
    logic        pid_ACK;
    logic        pid_DATA0;
    logic        pid_DATA1;
    logic [10:0] frame_no;
    logic        rx_data_done;
    logic        crc16_err;
    logic        seq_err;
    logic        tx_done;
    logic        tx_hs_req;
    logic [1:0]  tx_hs_pid;
    logic        tx_data_req;
    logic        tx_data_pid;

    modport slave (
        input  token_valid, token_fadr, token_endp, crc5_err,
        input  pid_OUT, pid_IN, pid_SETUP, pid_SOF, pid_ACK, pid_DATA0, pid_DATA1,
        input  frame_no, rx_data_done, crc16_err, seq_err, tx_done,
        output tx_hs_req, tx_hs_pid, tx_data_req, tx_data_pid
    );

    modport master (
        output token_valid, token_fadr, token_endp, crc5_err,
        output pid_OUT, pid_IN, pid_SETUP, pid_SOF, pid_ACK, pid_DATA0, pid_DATA1,
        output frame_no, rx_data_done, crc16_err, seq_err, tx_done,
        input  tx_hs_req, tx_hs_pid, tx_data_req, tx_data_pid
    );

endinterface

// File: rtl/usb1bd_pe_timer.sv
// ----------------------------------------------------------------------------
// usb1bd_pe_timer
// Bus-turnaround timeout counter. Counts while en is high, parks at the
// terminal value, and flags tc when the count equals TO_CYC-1.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clr         synchronous clear (wins over en)
//   en          count enable
//   tc          terminal count reached
// ----------------------------------------------------------------------------
module usb1bd_pe_timer
    import usb1bd_pe_pkg::*;
#(
    parameter int TO_CYC = TO_CYC_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int             W      = timer_width(TO_CYC);
    localparam logic [W-1:0]   TC_VAL = W'(TO_CYC - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && !tc)
            cnt <= cnt + 1'b1;
    end

    assign tc = (cnt == TC_VAL);

endmodule

// File: rtl/usb1bd_pe_ctrl.sv
// ----------------------------------------------------------------------------
// usb1bd_pe_ctrl
// USB 1.1 device protocol-engine sequencer. Matches tokens against the
// function address, runs OUT/SETUP receive, IN transmit and handshake
// selection, tracks per-endpoint data toggles, and abandons a transaction
// when the host stays silent for TO_CYC clocks.
// Ports:
//   clk, rst_n        core clock, asynchronous active-low reset
//   usb_rst           synchronous bus reset (same effect as rst_n)
//   fa[6:0]           assigned function address
//   bus               usb1bd_pe_ctrl_if.slave (tokens, PIDs, tx requests)
//   ep_stall/ep_out_rdy/ep_in_rdy[NUM_EP-1:0]  endpoint status
//   ep_sel[3:0]       endpoint of the current transaction
//   rx_en             data receive window open
//   out_commit, out_drop, in_commit, setup_rcvd   one-cycle buffer strobes
//   sof_pulse, sof_frame[10:0]                    SOF strobe / last frame no.
//   busy              sequencer not idle
//   err_cnt[7:0]      saturating error count (only with USB1BD_PE_ERRCNT_EN)
// Optional feature macro: USB1BD_PE_ERRCNT_EN
// ----------------------------------------------------------------------------
module usb1bd_pe_ctrl
    import usb1bd_pe_pkg::*;
#(
    parameter int NUM_EP = 4,
    parameter int TO_CYC = TO_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              usb_rst,
    input  logic [6:0]        fa,
    usb1bd_pe_ctrl_if.slave   bus,
    input  logic [NUM_EP-1:0] ep_stall,
    input  logic [NUM_EP-1:0] ep_out_rdy,
    input  logic [NUM_EP-1:0] ep_in_rdy,
`ifdef USB1BD_PE_ERRCNT_EN
    output logic [7:0]        err_cnt,
`endif
    output logic [3:0]        ep_sel,
    output logic              rx_en,
    output logic              out_commit,
    output logic              out_drop,
    output logic              in_commit,
    output logic              setup_rcvd,
    output logic              sof_pulse,
    output logic [10:0]       sof_frame,
    output logic              busy
);

    localparam logic [4:0] NUM_EP_V = 5'(NUM_EP);

    pe_state_t   state;
    pe_out_t     q;
    logic        cur_setup;
    logic [15:0] toggle;

    // Widen endpoint vectors to the full 4-bit endpoint space so they can be
    // indexed directly by token_endp / ep_sel; unimplemented bits read 0.
    logic [15:0] stall_v, out_rdy_v, in_rdy_v;
    assign stall_v   = 16'(ep_stall);
    assign out_rdy_v = 16'(ep_out_rdy);
    assign in_rdy_v  = 16'(ep_in_rdy);

    logic tok_ok, sof_hit, tok_hit, ack_hit, data_odd, timed, tmr_tc;

    assign tok_ok   = bus.token_valid & ~bus.crc5_err;
    assign sof_hit  = tok_ok & bus.pid_SOF;
    assign tok_hit  = tok_ok & (bus.token_fadr == fa)
                    & ({1'b0, bus.token_endp} < NUM_EP_V)
                    & (bus.pid_OUT | bus.pid_IN | bus.pid_SETUP);
    assign ack_hit  = bus.token_valid & bus.pid_ACK;
    assign data_odd = bus.pid_DATA1 & ~bus.pid_DATA0;
    assign timed    = (state == ST_RX_DATA) || (state == ST_WAIT_ACK);

    usb1bd_pe_timer #(.TO_CYC(TO_CYC)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (usb_rst | ~timed),
        .en    (timed),
        .tc    (tmr_tc)
    );

    // NOTE: all state here uses non-blocking assignments so every flop samples
    // the pre-edge values of its neighbours, regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            toggle    <= '0;
            cur_setup <= 1'b0;
            q         <= '0;
        end else if (usb_rst) begin
            state     <= ST_IDLE;
            toggle    <= '0;
            cur_setup <= 1'b0;
            q         <= '0;
        end else begin
            q.out_commit <= 1'b0;
            q.out_drop   <= 1'b0;
            q.in_commit  <= 1'b0;
            q.setup_rcvd <= 1'b0;
            q.sof_pulse  <= 1'b0;

            if (sof_hit) begin
                q.sof_frame <= bus.frame_no;
                q.sof_pulse <= 1'b1;
            end

            unique case (state)
                ST_IDLE: begin
                    if (tok_hit) begin
                        q.ep_sel  <= bus.token_endp;
                        cur_setup <= bus.pid_SETUP;
                        if (bus.pid_OUT | bus.pid_SETUP) begin
                            state   <= ST_RX_DATA;
                            q.rx_en <= 1'b1;
                            // A SETUP stage always restarts control with DATA0.
                            if (bus.pid_SETUP && bus.token_endp == 4'd0)
                                toggle[0] <= 1'b0;
                        end else if (stall_v[bus.token_endp]) begin
                            state       <= ST_RX_HS;
                            q.tx_hs_req <= 1'b1;
                            q.tx_hs_pid <= HS_STALL;
                        end else if (!in_rdy_v[bus.token_endp]) begin
                            state       <= ST_RX_HS;
                            q.tx_hs_req <= 1'b1;
                            q.tx_hs_pid <= HS_NAK;
                        end else begin
                            state         <= ST_TX_DATA;
                            q.tx_data_req <= 1'b1;
                            q.tx_data_pid <= toggle[bus.token_endp];
                        end
                    end
                end

                ST_RX_DATA: begin
                    if (bus.rx_data_done) begin
                        q.rx_en <= 1'b0;
                        if (bus.crc16_err | bus.seq_err) begin
                            // Corrupt data gets no handshake; host will retry.
                            q.out_drop <= 1'b1;
                            state      <= ST_IDLE;
                        end else begin
                            state       <= ST_RX_HS;
                            q.tx_hs_req <= 1'b1;
                            if (cur_setup) begin
                                q.tx_hs_pid  <= HS_ACK;
                                toggle[0]    <= 1'b1;
                                q.out_commit <= 1'b1;
                                q.setup_rcvd <= 1'b1;
                            end else if (stall_v[q.ep_sel]) begin
                                q.tx_hs_pid <= HS_STALL;
                                q.out_drop  <= 1'b1;
                            end else if (!out_rdy_v[q.ep_sel]) begin
                                q.tx_hs_pid <= HS_NAK;
                                q.out_drop  <= 1'b1;
                            end else if (data_odd != toggle[q.ep_sel]) begin
                                // Resend of a packet we already kept: ACK it
                                // again so the host advances, but discard.
                                q.tx_hs_pid <= HS_ACK;
                                q.out_drop  <= 1'b1;
                            end else begin
                                q.tx_hs_pid       <= HS_ACK;
                                q.out_commit      <= 1'b1;
                                toggle[q.ep_sel]  <= ~toggle[q.ep_sel];
                            end
                        end
                    end else if (tmr_tc) begin
                        q.rx_en    <= 1'b0;
                        q.out_drop <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end

                ST_RX_HS: begin
                    if (bus.tx_done) begin
                        q.tx_hs_req <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end

                ST_TX_DATA: begin
                    if (bus.tx_done) begin
                        q.tx_data_req <= 1'b0;
                        state         <= ST_WAIT_ACK;
                    end
                end

                ST_WAIT_ACK: begin
                    // ACK is checked first so it wins a same-cycle timeout.
                    if (ack_hit) begin
                        q.in_commit      <= 1'b1;
                        toggle[q.ep_sel] <= ~toggle[q.ep_sel];
                        state            <= ST_IDLE;
                    end else if (tmr_tc) begin
                        state <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef USB1BD_PE_ERRCNT_EN
    logic err_evt;
    assign err_evt = (bus.token_valid & bus.crc5_err)
                   | ((state == ST_RX_DATA) & bus.rx_data_done & (bus.crc16_err | bus.seq_err))
                   | ((state == ST_RX_DATA) & ~bus.rx_data_done & tmr_tc)
                   | ((state == ST_WAIT_ACK) & ~ack_hit & tmr_tc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_cnt <= '0;
        else if (usb_rst)
            err_cnt <= '0;
        else if (err_evt && err_cnt != 8'hFF)
            err_cnt <= err_cnt + 8'd1;
    end
`endif

    assign bus.tx_hs_req   = q.tx_hs_req;
    assign bus.tx_hs_pid   = q.tx_hs_pid;
    assign bus.tx_data_req = q.tx_data_req;
    assign bus.tx_data_pid = q.tx_data_pid;
    assign ep_sel          = q.ep_sel;
    assign rx_en           = q.rx_en;
    assign out_commit      = q.out_commit;
    assign out_drop        = q.out_drop;
    assign in_commit       = q.in_commit;
    assign setup_rcvd      = q.setup_rcvd;
    assign sof_pulse       = q.sof_pulse;
    assign sof_frame       = q.sof_frame;
    assign busy            = (state != ST_IDLE);

endmodule

// File: tb/tb_usb1bd_pe_ctrl.sv
// ----------------------------------------------------------------------------
// tb_usb1bd_pe_ctrl
// Directed self-checking bench for usb1bd_pe_ctrl (NUM_EP=4, TO_CYC=96,
// fa=5). Inputs change and outputs are sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_usb1bd_pe_ctrl;

    localparam int NUM_EP = 4;
    localparam int TO_CYC = 96;

    typedef enum {K_OUT, K_IN, K_SETUP, K_SOF, K_ACK} kind_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              usb_rst;
    logic [6:0]        fa;
    logic [NUM_EP-1:0] ep_stall, ep_out_rdy, ep_in_rdy;
    logic [3:0]        ep_sel;
    logic              rx_en, out_commit, out_drop, in_commit, setup_rcvd;
    logic              sof_pulse, busy;
    logic [10:0]       sof_frame;
`ifdef USB1BD_PE_ERRCNT_EN
    logic [7:0]        err_cnt;
`endif

    int n_vec = 0;
    int n_bad = 0;

    usb1bd_pe_ctrl_if bus ();

    usb1bd_pe_ctrl #(.NUM_EP(NUM_EP), .TO_CYC(TO_CYC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .usb_rst    (usb_rst),
        .fa         (fa),
        .bus        (bus),
        .ep_stall   (ep_stall),
        .ep_out_rdy (ep_out_rdy),
        .ep_in_rdy  (ep_in_rdy),
`ifdef USB1BD_PE_ERRCNT_EN
        .err_cnt    (err_cnt),
`endif
        .ep_sel     (ep_sel),
        .rx_en      (rx_en),
        .out_commit (out_commit),
        .out_drop   (out_drop),
        .in_commit  (in_commit),
        .setup_rcvd (setup_rcvd),
        .sof_pulse  (sof_pulse),
        .sof_frame  (sof_frame),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // NOTE: stimulus is driven with blocking assignments at the falling edge,
    // well clear of the rising edge where the DUT samples it.
    task automatic token(input kind_t k, input logic [6:0] adr, input logic [3:0] ep,
                         input logic crc = 1'b0);
        bus.pid_OUT     = (k == K_OUT);
        bus.pid_IN      = (k == K_IN);
        bus.pid_SETUP   = (k == K_SETUP);
        bus.pid_SOF     = (k == K_SOF);
        bus.pid_ACK     = (k == K_ACK);
        bus.token_fadr  = adr;
        bus.token_endp  = ep;
        bus.crc5_err    = crc;
        bus.token_valid = 1'b1;
        tick();
        bus.token_valid = 1'b0;
        bus.crc5_err    = 1'b0;
        {bus.pid_OUT, bus.pid_IN, bus.pid_SETUP, bus.pid_SOF, bus.pid_ACK} = '0;
    endtask

    task automatic rx_data(input logic odd, input logic crc = 1'b0, input logic seq = 1'b0);
        bus.pid_DATA1    = odd;
        bus.pid_DATA0    = ~odd;
        bus.crc16_err    = crc;
        bus.seq_err      = seq;
        bus.rx_data_done = 1'b1;
        tick();
        bus.rx_data_done = 1'b0;
        bus.crc16_err    = 1'b0;
        bus.seq_err      = 1'b0;
        bus.pid_DATA1    = 1'b0;
        bus.pid_DATA0    = 1'b0;
    endtask

    task automatic done_pulse();
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;  usb_rst = 1'b0;  fa = 7'd5;
        ep_stall = '0; ep_out_rdy = '1; ep_in_rdy = '1;
        bus.token_valid = 1'b0; bus.token_fadr = '0; bus.token_endp = '0;
        bus.crc5_err = 1'b0; bus.frame_no = '0;
        {bus.pid_OUT, bus.pid_IN, bus.pid_SETUP, bus.pid_SOF, bus.pid_ACK} = '0;
        bus.pid_DATA0 = 1'b0; bus.pid_DATA1 = 1'b0;
        bus.rx_data_done = 1'b0; bus.crc16_err = 1'b0; bus.seq_err = 1'b0;
        bus.tx_done = 1'b0;

        // Reset state
        tick(2);
        check("rst_busy",     busy, 0);
        check("rst_hs_req",   bus.tx_hs_req, 0);
        check("rst_data_req", bus.tx_data_req, 0);
        check("rst_rx_en",    rx_en, 0);
        check("rst_sof",      sof_frame, 0);
        rst_n = 1'b1;
        tick();

        // OUT ep1 DATA0, toggle 0 -> ACK + commit; SOF while busy still seen
        token(K_OUT, 7'd5, 4'd1);
        check("out1_busy",  busy, 1);
        check("out1_rx_en", rx_en, 1);
        check("out1_ep",    ep_sel, 1);
        check("out1_noreq", bus.tx_hs_req, 0);
        bus.frame_no = 11'h045;
        token(K_SOF, 7'd0, 4'd0);
        check("sof_busy_pulse", sof_pulse, 1);
        check("sof_busy_frame", sof_frame, 11'h045);
        check("sof_busy_state", busy, 1);
        rx_data(1'b0);
        check("out1_hs_req", bus.tx_hs_req, 1);
        check("out1_hs_pid", bus.tx_hs_pid, 2'b00);
        check("out1_commit", out_commit, 1);
        check("out1_drop",   out_drop, 0);
        check("out1_rx_off", rx_en, 0);
        tick();
        check("out1_commit_once", out_commit, 0);
        check("out1_hs_held", bus.tx_hs_req, 1);
        done_pulse();
        check("out1_hs_done", bus.tx_hs_req, 0);
        check("out1_idle",    busy, 0);

        // Repeat DATA0 on ep1 (toggle now 1) -> ACK, drop
        token(K_OUT, 7'd5, 4'd1);
        rx_data(1'b0);
        check("out2_hs_pid", bus.tx_hs_pid, 2'b00);
        check("out2_drop",   out_drop, 1);
        check("out2_commit", out_commit, 0);
        done_pulse();

        // DATA1 on ep1 proves toggle stayed 1 -> commit, toggle back to 0
        token(K_OUT, 7'd5, 4'd1);
        rx_data(1'b1);
        check("out3_commit", out_commit, 1);
        check("out3_drop",   out_drop, 0);
        done_pulse();

        // IN ep2 -> DATA0, ACK after 10 clocks -> in_commit
        token(K_IN, 7'd5, 4'd2);
        check("in1_data_req", bus.tx_data_req, 1);
        check("in1_data_pid", bus.tx_data_pid, 0);
        check("in1_no_hs",    bus.tx_hs_req, 0);
        done_pulse();
        check("in1_req_off",  bus.tx_data_req, 0);
        check("in1_wait",     busy, 1);
        tick(10);
        token(K_ACK, 7'd0, 4'd0);
        check("in1_commit",   in_commit, 1);
        check("in1_idle",     busy, 0);
        tick();
        check("in1_commit_once", in_commit, 0);

        // IN ep2 -> DATA1, no ACK -> timeout after 96 clocks, no flip
        token(K_IN, 7'd5, 4'd2);
        check("in2_data_pid", bus.tx_data_pid, 1);
        done_pulse();
        tick(TO_CYC - 1);
        check("in2_pre_to",   busy, 1);
        tick();
        check("in2_timeout",  busy, 0);
        check("in2_no_commit", in_commit, 0);
        token(K_IN, 7'd5, 4'd2);
        check("in3_data_pid", bus.tx_data_pid, 1);
        done_pulse();
        token(K_ACK, 7'd0, 4'd0);
        check("in3_commit", in_commit, 1);

        // Stalled OUT ep1 -> STALL; SETUP ep0 ignores stall
        ep_stall = 4'b0011;
        token(K_OUT, 7'd5, 4'd1);
        rx_data(1'b0);
        check("stall_hs_pid", bus.tx_hs_pid, 2'b10);
        check("stall_drop",   out_drop, 1);
        done_pulse();
        token(K_SETUP, 7'd5, 4'd0);
        check("setup_rx_en", rx_en, 1);
        rx_data(1'b0);
        check("setup_hs_pid", bus.tx_hs_pid, 2'b00);
        check("setup_commit", out_commit, 1);
        check("setup_rcvd",   setup_rcvd, 1);
        done_pulse();
        ep_stall = '0;
        // toggle[0] is now 1, so DATA0 is a resend
        token(K_OUT, 7'd5, 4'd0);
        rx_data(1'b0);
        check("ep0_tog_drop", out_drop, 1);
        check("ep0_tog_ack",  bus.tx_hs_pid, 2'b00);
        done_pulse();

        // NAK for OUT when not ready, and for IN when empty
        ep_out_rdy = 4'b1101;
        token(K_OUT, 7'd5, 4'd1);
        rx_data(1'b0);
        check("nak_out_pid",  bus.tx_hs_pid, 2'b01);
        check("nak_out_drop", out_drop, 1);
        done_pulse();
        ep_out_rdy = '1;
        ep_in_rdy = 4'b1011;
        token(K_IN, 7'd5, 4'd2);
        check("nak_in_hs",   bus.tx_hs_req, 1);
        check("nak_in_pid",  bus.tx_hs_pid, 2'b01);
        check("nak_in_data", bus.tx_data_req, 0);
        done_pulse();
        ep_in_rdy = '1;

        // Ignored tokens: wrong address, CRC error, endpoint beyond NUM_EP
        token(K_OUT, 7'd6, 4'd1);
        check("badadr_busy",  busy, 0);
        check("badadr_rx_en", rx_en, 0);
        token(K_IN, 7'd5, 4'd1, 1'b1);
        check("crc5_busy",    busy, 0);
        check("crc5_data",    bus.tx_data_req, 0);
        token(K_IN, 7'd5, 4'd4);
        check("ep4_busy",     busy, 0);
        check("ep4_data",     bus.tx_data_req, 0);

        // SOF while idle
        bus.frame_no = 11'h123;
        token(K_SOF, 7'd0, 4'd0);
        check("sof_pulse", sof_pulse, 1);
        check("sof_frame", sof_frame, 11'h123);
        check("sof_idle",  busy, 0);
        tick();
        check("sof_pulse_once", sof_pulse, 0);

        // crc16 error -> drop, no handshake
        token(K_OUT, 7'd5, 4'd1);
        rx_data(1'b0, 1'b1);
        check("crc16_drop", out_drop, 1);
        check("crc16_hs",   bus.tx_hs_req, 0);
        check("crc16_idle", busy, 0);

        // Host never sends DATA -> drop after 96 clocks
        token(K_OUT, 7'd5, 4'd1);
        tick(TO_CYC - 1);
        check("rxto_pre",  busy, 1);
        tick();
        check("rxto_idle", busy, 0);
        check("rxto_drop", out_drop, 1);
        check("rxto_rx_en", rx_en, 0);

        // Set toggle[3]=1, then bus reset mid-WAIT_ACK clears it
        token(K_IN, 7'd5, 4'd3);
        check("ep3_pid0", bus.tx_data_pid, 0);
        done_pulse();
        token(K_ACK, 7'd0, 4'd0);
        token(K_IN, 7'd5, 4'd3);
        check("ep3_pid1", bus.tx_data_pid, 1);
        done_pulse();
        tick(5);
        usb_rst = 1'b1;
        tick();
        usb_rst = 1'b0;
        check("usbrst_busy", busy, 0);
        check("usbrst_sof",  sof_frame, 0);
        check("usbrst_ep",   ep_sel, 0);
        token(K_IN, 7'd5, 4'd3);
        check("usbrst_tog3", bus.tx_data_pid, 0);
        done_pulse();
        token(K_ACK, 7'd0, 4'd0);
        check("usbrst_in_commit", in_commit, 1);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
